phase_serializer: RTL and testbench
===================================

PHASE_SERIALIZER -- requirements
Module: phase_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port clock, input, 1 bit: the single clock; all state updates on posedge clock.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset; state clears on negedge reset.
REQ-004 SHALL have port data_in, input, WIDTH bits: parallel word from the half-rate producer.
REQ-005 SHALL have port data_valid, input, 1 bit: producer offers data_in this cycle.
REQ-006 SHALL have port data_ready, output, 1 bit: the block accepts data_in this cycle.
REQ-007 SHALL have port phase, output, 1 bit: registered half-rate toggle, the clock-enable of the producer domain.
REQ-008 SHALL have port d_out, output, 1 bit: registered serial bit stream.
REQ-009 SHALL have port frame, output, 1 bit: high in the cycle d_out carries a word's MSB.
REQ-010 SHALL have port busy, output, 1 bit: high while a word is being shifted or is held.

Function
REQ-011 SHALL toggle phase every clock; phase is 0 after reset and 1 after the first clock edge.
REQ-012 SHALL drive data_ready = phase AND (holding register empty), purely combinational from registered state.
REQ-013 SHALL accept a word on a posedge where data_valid and data_ready are both high; data_valid while phase=0 is ignored and not lost if held.
REQ-014 SHALL store an accepted word in a one-entry holding register.
REQ-015 SHALL implement FSM states IDLE and SHIFT; IDLE->SHIFT when the holding register is full; SHIFT->IDLE after the last bit if the holding register is empty.
REQ-016 SHALL load the shifter from the holding register on the edge after acceptance; the MSB appears on d_out with frame=1 one cycle after the acceptance edge.
REQ-017 SHALL shift out MSB first, one bit per clock, for L cycles (L = WIDTH, or WIDTH+1 with parity).
REQ-018 SHALL, when the holding register is full on the last-bit cycle, load it directly so the next MSB follows with no idle gap (back-to-back).
REQ-019 SHALL hold d_out=0 and frame=0 in IDLE.
REQ-020 SHALL drive busy=1 when the state is SHIFT or the holding register is full, and busy=0 otherwise.
REQ-021 SHALL use a bit counter of width clog2(WIDTH+2) that wraps to 0 on word completion.

Reset
REQ-022 SHALL, on reset low, immediately force phase=0, d_out=0, frame=0, busy=0, FSM=IDLE, counter=0, and the holding register empty.
REQ-023 SHALL discard any partially shifted or held word when reset is asserted mid-operation; no residual bits appear after release.
REQ-024 SHALL keep data_ready=0 while reset is low and on the first cycle after release (phase=0).

Configuration
REQ-025 SHALL, with macro PHASE_SERIALIZER_PARITY_EN defined, append one even-parity bit (XOR of the word) after the LSB, giving L = WIDTH+1.
REQ-026 SHALL, without PHASE_SERIALIZER_PARITY_EN, emit exactly WIDTH bits per word, with no parity logic present.

Verification
REQ-027 Bench SHALL cover: WIDTH=8, no parity, send 0xA5 -> d_out 1,0,1,0,0,1,0,1 on consecutive cycles, frame only on the first bit, then d_out=0 and busy=0.
REQ-028 Bench SHALL cover: data_valid raised while phase=0 -> no acceptance that cycle; acceptance on the next cycle (phase=1); first bit one cycle later.
REQ-029 Bench SHALL cover: 0xF0 then 0x0F offered back-to-back -> 16 contiguous bits 11110000 00001111, frame on bits 0 and 8, with no gap.
REQ-030 Bench SHALL cover: reset pulled low on the 4th bit of 0xFF -> d_out=0 and busy=0 immediately; after release, d_out stays 0 until a new word is accepted.
REQ-031 Bench SHALL cover: parity enabled, send 0xA5 -> 9th bit 0; send 0x07 -> 9th bit 1; next word begins on the cycle after the parity bit.
REQ-032 Bench SHALL cover: holding register full while shifting -> data_ready=0 regardless of phase until the holding register is loaded into the shifter.

Source files
------------

// File: rtl/phase_serializer.sv
// phase_serializer: serializes WIDTH-bit words, MSB first, from a half-rate producer.
// The producer's clock-enable is the registered 'phase' toggle. A one-entry holding
// register lets the next word load back-to-back with no gap between frames.
// Optional feature: define PHASE_SERIALIZER_PARITY_EN to append an even-parity bit after the LSB.
module phase_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             phase,
    output logic             d_out,
    output logic             frame,
    output logic             busy
);

`ifdef PHASE_SERIALIZER_PARITY_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] LAST = CW'(LEN - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    state_t           next_state;
    logic             hold_full;
    logic [WIDTH-1:0] hold_data;
    logic [LEN-1:0]   shift_reg;
    logic [LEN-1:0]   load_word;
    logic [CW-1:0]    bit_cnt;
    logic             accept;
    logic             load;
    logic             advance;
    logic             finish;

    assign data_ready = phase & ~hold_full;
    assign accept     = data_valid & data_ready;
    assign busy       = (state == SHIFT) | hold_full;

`ifdef PHASE_SERIALIZER_PARITY_EN
    assign load_word = {hold_data, ^hold_data};
`else
    assign load_word = hold_data;
`endif

    // Half-rate toggle that paces the producer domain
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
        end
    end

    // One-entry holding register: filled on acceptance, emptied when the shifter loads it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_full <= 1'b0;
            hold_data <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_data <= data_in;
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and shifter control; a full holding register on the last bit reloads immediately
    always_comb begin
        next_state = state;
        load       = 1'b0;
        advance    = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (hold_full) begin
                    load       = 1'b1;
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end
                end else begin
                    advance = 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Serial datapath: d_out shows bit number bit_cnt of the current frame, MSB first
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            d_out     <= 1'b0;
            frame     <= 1'b0;
        end else if (load) begin
            d_out     <= load_word[LEN-1];
            shift_reg <= load_word << 1;
            frame     <= 1'b1;
            bit_cnt   <= '0;
        end else if (advance) begin
            d_out     <= shift_reg[LEN-1];
            shift_reg <= shift_reg << 1;
            frame     <= 1'b0;
            bit_cnt   <= bit_cnt + CW'(1);
        end else if (finish) begin
            d_out     <= 1'b0;
            frame     <= 1'b0;
            bit_cnt   <= '0;
        end
    end

endmodule

// File: tb/tb_phase_serializer.sv
// tb_phase_serializer: directed, self-checking bench for phase_serializer (WIDTH=8).
// Parity-specific vectors are compiled in when PHASE_SERIALIZER_PARITY_EN is defined.
module tb_phase_serializer;

    localparam int WIDTH = 8;
`ifdef PHASE_SERIALIZER_PARITY_EN
    localparam int LEN = WIDTH + 1;
`else
    localparam int LEN = WIDTH;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    logic             phase;
    logic             d_out;
    logic             frame;
    logic             busy;

    int vectors     = 0;
    int miscompares = 0;

    phase_serializer #(.WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .phase      (phase),
        .d_out      (d_out),
        .frame      (frame),
        .busy       (busy)
    );

    // Free-running clock, 10 time-unit period
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] word);
        data_valid = valid;
        data_in    = word;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic waitPhase(input logic want);
        int n = 0;
        while (phase !== want && n < 8) begin
            step();
            n++;
        end
        checkOutput("phase_wait", 32'(phase), 32'(want));
    endtask

    // Walks nbits of serial output starting from the current cycle, then checks the idle tail
    task automatic streamCheck(input string tag, input logic [63:0] exp, input int nbits, input bit b2b);
        for (int i = 0; i < nbits; i++) begin
            checkOutput({tag, "_bit"}, 32'(d_out), 32'(exp[nbits-1-i]));
            checkOutput({tag, "_frame"}, 32'(frame), 32'((i % LEN) == 0));
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            if (b2b && i >= 1 && i <= LEN - 1) begin
                checkOutput({tag, "_ready_held"}, 32'(data_ready), 32'd0);
            end
            if (i == 1) begin
                applyStimulus(1'b0, '0);
            end
            step();
        end
        checkOutput({tag, "_tail_dout"}, 32'(d_out), 32'd0);
        checkOutput({tag, "_tail_frame"}, 32'(frame), 32'd0);
        checkOutput({tag, "_tail_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic singleWord(input string tag, input logic [WIDTH-1:0] word, input logic [63:0] exp);
        waitPhase(1'b1);
        applyStimulus(1'b1, word);
        step();
        applyStimulus(1'b0, '0);
        checkOutput({tag, "_held_busy"}, 32'(busy), 32'd1);
        checkOutput({tag, "_held_dout"}, 32'(d_out), 32'd0);
        checkOutput({tag, "_held_ready"}, 32'(data_ready), 32'd0);
        step();
        streamCheck(tag, exp, LEN, 1'b0);
    endtask

    task automatic backToBack(input string tag, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1, input logic [63:0] exp);
        waitPhase(1'b1);
        applyStimulus(1'b1, w0);
        step();
        applyStimulus(1'b1, w1);
        checkOutput({tag, "_first_held_ready"}, 32'(data_ready), 32'd0);
        step();
        streamCheck(tag, exp, 2 * LEN, 1'b1);
    endtask

    // Directed test sequence
    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, '0);
        step();
        step();
        checkOutput("rst_phase", 32'(phase), 32'd0);
        checkOutput("rst_dout", 32'(d_out), 32'd0);
        checkOutput("rst_frame", 32'(frame), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ready", 32'(data_ready), 32'd0);
        reset = 1'b1;
        checkOutput("rel_ready", 32'(data_ready), 32'd0);
        step();
        checkOutput("rel_phase1", 32'(phase), 32'd1);
        checkOutput("rel_ready1", 32'(data_ready), 32'd1);

        $display("[TB] single word 0xA5");
`ifdef PHASE_SERIALIZER_PARITY_EN
        singleWord("a5", 8'hA5, 64'(9'b10100101_0));
`else
        singleWord("a5", 8'hA5, 64'(8'b10100101));
`endif

        $display("[TB] valid raised while phase=0");
        waitPhase(1'b1);
        step();
        applyStimulus(1'b1, 8'hC3);
        checkOutput("p0_ready", 32'(data_ready), 32'd0);
        step();
        checkOutput("p0_not_taken", 32'(busy), 32'd0);
        checkOutput("p0_phase", 32'(phase), 32'd1);
        checkOutput("p0_ready_next", 32'(data_ready), 32'd1);
        step();
        applyStimulus(1'b0, '0);
        checkOutput("p0_taken", 32'(busy), 32'd1);
        checkOutput("p0_dout_wait", 32'(d_out), 32'd0);
        step();
`ifdef PHASE_SERIALIZER_PARITY_EN
        streamCheck("c3", 64'(9'b11000011_0), LEN, 1'b0);
`else
        streamCheck("c3", 64'(8'b11000011), LEN, 1'b0);
`endif

        $display("[TB] back-to-back 0xF0, 0x0F");
`ifdef PHASE_SERIALIZER_PARITY_EN
        backToBack("b2b", 8'hF0, 8'h0F, 64'(18'b11110000_0_00001111_0));
`else
        backToBack("b2b", 8'hF0, 8'h0F, 64'(16'b11110000_00001111));
`endif

`ifdef PHASE_SERIALIZER_PARITY_EN
        $display("[TB] parity 0xA5 then 0x07");
        backToBack("par", 8'hA5, 8'h07, 64'(18'b10100101_0_00000111_1));
`endif

        $display("[TB] reset during 0xFF");
        waitPhase(1'b1);
        applyStimulus(1'b1, 8'hFF);
        step();
        applyStimulus(1'b0, '0);
        step();
        step();
        step();
        step();
        checkOutput("mid_bit3", 32'(d_out), 32'd1);
        checkOutput("mid_busy", 32'(busy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_dout", 32'(d_out), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_frame", 32'(frame), 32'd0);
        checkOutput("mid_rst_phase", 32'(phase), 32'd0);
        step();
        step();
        reset = 1'b1;
        checkOutput("mid_rel_ready", 32'(data_ready), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step();
            checkOutput("mid_after_dout", 32'(d_out), 32'd0);
            checkOutput("mid_after_busy", 32'(busy), 32'd0);
        end

        $display("[TB] single word after reset recovery");
`ifdef PHASE_SERIALIZER_PARITY_EN
        singleWord("post", 8'h81, 64'(9'b10000001_0));
`else
        singleWord("post", 8'h81, 64'(8'b10000001));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
